// File: rtl/toggle_rx_pkg.sv
// Shared types for the toggle-encoded event receiver.
// Holds the receiver FSM state encoding.
package toggle_rx_pkg;
  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_QUAL = 2'd2
  } rx_state_t;
endpackage

// File: rtl/sync_chain.sv
// Reusable multi-flop synchroniser for a single asynchronous bit.
// Every stage resets to 0.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= {STAGES{1'b0}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];
endmodule

// File: rtl/toggle_event_rx.sv
// Receiver for a toggle-encoded event line: synchronise, deglitch, and turn each
// accepted level change into one queued event handed out over valid/ready.
module toggle_event_rx
  import toggle_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             out
);
  localparam int QW = $clog2(FILTER_LEN + 1);
  localparam int IW = $clog2(SYNC_STAGES + 1);

  logic             w_in_s;
  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic             r_lvl;
  logic             w_lvl_nxt;
  logic [QW-1:0]    r_qual_cnt;
  logic [QW-1:0]    w_qual_nxt;
  logic [IW-1:0]    r_init_cnt;
  logic [IW-1:0]    w_init_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic [CNT_W-1:0] r_pending;
  logic             r_ovf;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (in),
    .q      (w_in_s)
  );

  // FSM, level tracker and counter registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_INIT;
      r_lvl      <= 1'b0;
      r_qual_cnt <= {QW{1'b0}};
      r_init_cnt <= {IW{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_lvl      <= w_lvl_nxt;
      r_qual_cnt <= w_qual_nxt;
      r_init_cnt <= w_init_nxt;
    end
  end

  // Next-state logic. INIT stays one edge past chain fill so lvl captures the settled line.
  always_comb begin
    w_state_nxt = r_state;
    w_lvl_nxt   = r_lvl;
    w_qual_nxt  = r_qual_cnt;
    w_init_nxt  = r_init_cnt;
    w_push      = 1'b0;
    case (r_state)
      S_INIT: begin
        w_lvl_nxt = w_in_s;
        if (r_init_cnt == IW'(SYNC_STAGES)) begin
          w_state_nxt = S_IDLE;
          w_init_nxt  = {IW{1'b0}};
        end else begin
          w_init_nxt = r_init_cnt + IW'(1);
        end
      end
      S_IDLE: begin
        if (w_in_s != r_lvl) begin
          if (FILTER_LEN == 1) begin
            w_push    = 1'b1;
            w_lvl_nxt = ~r_lvl;
          end else begin
            w_qual_nxt  = QW'(1);
            w_state_nxt = S_QUAL;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_QUAL: begin
        if (w_in_s == r_lvl) begin
          w_qual_nxt  = {QW{1'b0}};
          w_state_nxt = S_IDLE;
        end else if (r_qual_cnt == QW'(FILTER_LEN - 1)) begin
          w_push      = 1'b1;
          w_lvl_nxt   = ~r_lvl;
          w_qual_nxt  = {QW{1'b0}};
          w_state_nxt = S_IDLE;
        end else begin
          w_qual_nxt = r_qual_cnt + QW'(1);
        end
      end
      default: begin
        w_state_nxt = S_INIT;
      end
    endcase
  end

  assign w_full = (r_pending == {CNT_W{1'b1}});
  assign w_pop  = evt_valid && evt_ready;

  // Pending-event counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_pending <= {CNT_W{1'b0}};
    end else if (w_push && !w_pop && !w_full) begin
      r_pending <= r_pending + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      r_pending <= r_pending - CNT_W'(1);
    end
  end

  // Sticky overflow; setting wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ovf <= 1'b0;
    end else if (w_push && !w_pop && w_full) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign evt_valid = (r_pending != {CNT_W{1'b0}});
  assign pending   = r_pending;
  assign overflow  = r_ovf;
  assign out       = r_lvl;
endmodule

// File: tb/tb_toggle_event_rx.sv
// Self-checking bench for toggle_event_rx with default parameters; expected
// levels are queued on each toggle and popped when the filtered output changes.
module tb_toggle_event_rx;
  import toggle_rx_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in;
  logic       evt_ready;
  logic       clr_ovf;
  logic       evt_valid;
  logic [2:0] pending;
  logic       overflow;
  logic       out;

  int n_checks = 0;
  int n_pass   = 0;
  bit exp_q[$];
  int model_pend;
  bit model_ovf;

  always #5 clk = ~clk;

  toggle_event_rx #(.SYNC_STAGES(2), .FILTER_LEN(2), .CNT_W(3)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in        (in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .pending   (pending),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .out       (out)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit lvl);
    in     = lvl;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(6);
    exp_q.delete();
    model_pend = 0;
    model_ovf  = 1'b0;
  endtask

  task automatic do_toggle(input string tag, input bit ready_at_accept);
    bit prev;
    bit e;
    int cnt;
    prev = out;
    in   = ~in;
    exp_q.push_back(in);
    cnt = 0;
    while (out === prev && cnt < 12) begin
      if (ready_at_accept && cnt == 3) evt_ready = 1'b1;
      tick(1);
      cnt++;
    end
    evt_ready = 1'b0;
    n_checks++;
    if (out === prev) $display("FAIL %s_timeout: out stayed %b for %0d edges", tag, out, cnt);
    else n_pass++;
    e = exp_q.pop_front();
    n_checks++;
    if (out !== e) $display("FAIL %s_level: got %b expected %b", tag, out, e);
    else n_pass++;
    n_checks++;
    if (cnt != 4) $display("FAIL %s_latency: got %0d edges expected 4", tag, cnt);
    else n_pass++;
    if (!(ready_at_accept && model_pend > 0)) begin
      if (model_pend == 7) model_ovf = 1'b1;
      else model_pend++;
    end
    n_checks++;
    if (pending !== 3'(model_pend) || evt_valid !== (model_pend != 0))
      $display("FAIL %s_pending: got %0d/%b expected %0d", tag, pending, evt_valid, model_pend);
    else n_pass++;
    n_checks++;
    if (overflow !== model_ovf) $display("FAIL %s_ovf: got %b expected %b", tag, overflow, model_ovf);
    else n_pass++;
    tick(3);
  endtask

  task automatic test_reset();
    bit bad;
    in = 1'b1;
    resetn = 1'b0;
    tick(2);
    n_checks++;
    if (out !== 1'b0 || pending !== 3'd0 || evt_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL reset_vals: out=%b pend=%0d valid=%b ovf=%b expected all 0", out, pending, evt_valid, overflow);
    else n_pass++;
    resetn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (pending !== 3'd0 || evt_valid !== 1'b0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL reset_no_event: pend=%0d valid=%b expected 0/0", pending, evt_valid);
    else n_pass++;
    n_checks++;
    if (out !== 1'b1) $display("FAIL reset_out: got %b expected 1", out);
    else n_pass++;
  endtask

  task automatic test_single_toggle();
    do_reset(1'b0);
    do_toggle("single", 1'b0);
  endtask

  task automatic test_glitch();
    bit bad;
    bit saw_qual;
    do_reset(1'b0);
    in = 1'b1;
    tick(1);
    in = 1'b0;
    bad = 1'b0;
    saw_qual = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (dut.r_state == S_QUAL) saw_qual = 1'b1;
      if (out !== 1'b0 || pending !== 3'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad) $display("FAIL glitch_reject: out=%b pend=%0d expected 0/0", out, pending);
    else n_pass++;
    n_checks++;
    if (!saw_qual) $display("FAIL glitch_qual: state %0d never reached S_QUAL", dut.r_state);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int pops;
    do_reset(1'b0);
    for (int i = 0; i < 8; i++) do_toggle($sformatf("ovf%0d", i), 1'b0);
    clr_ovf = 1'b1;
    tick(1);
    clr_ovf = 1'b0;
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", overflow);
    else n_pass++;
    evt_ready = 1'b1;
    pops = 0;
    while (evt_valid && pops < 20) begin
      tick(1);
      pops++;
    end
    tick(3);
    evt_ready = 1'b0;
    n_checks++;
    if (pops != model_pend || pending !== 3'd0)
      $display("FAIL drain: popped %0d pend=%0d expected %0d/0", pops, pending, model_pend);
    else n_pass++;
    model_pend = 0;
  endtask

  task automatic test_back_to_back();
    do_reset(1'b0);
    do_toggle("b2b_first", 1'b0);
    do_toggle("b2b_pushpop", 1'b1);
  endtask

  task automatic test_async_reset();
    bit bad;
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) do_toggle($sformatf("ar%0d", i), 1'b0);
    in = ~in;
    tick(3);
    n_checks++;
    if (dut.r_state != S_QUAL) $display("FAIL ar_in_qual: state %0d expected S_QUAL", dut.r_state);
    else n_pass++;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (out !== 1'b0 || pending !== 3'd0 || evt_valid !== 1'b0 || overflow !== 1'b0)
      $display("FAIL ar_async: out=%b pend=%0d valid=%b ovf=%b expected all 0", out, pending, evt_valid, overflow);
    else n_pass++;
    tick(1);
    resetn = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (pending !== 3'd0) bad = 1'b1;
    end
    n_checks++;
    if (bad || out !== in) $display("FAIL ar_reinit: pend=%0d out=%b expected 0/%b", pending, out, in);
    else n_pass++;
  endtask

  initial begin
    resetn    = 1'b0;
    in        = 1'b0;
    evt_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_pend = 0;
    model_ovf  = 1'b0;
    test_reset();
    test_single_toggle();
    test_glitch();
    test_overflow();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
